// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch slice: default datapath width and reset
// vector, base opcodes decoded from instr[6:0], and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    ERR
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment.
//  imem_req/imem_addr      : request strobe and word address to instruction memory
//  imem_rvalid/imem_rdata  : memory response
//  instr_valid/instr/instr_pc/instr_ready : held instruction towards decode, consume strobe
//  pc_src/pc_target        : branch redirect, sampled on consume
//  flush/flush_pc          : discard everything and restart at flush_pc
//  fetch_err               : sticky memory timeout flag
// master = fetch unit side, slave = memory/core side.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    input  imem_rvalid, imem_rdata, instr_ready, pc_src, pc_target, flush, flush_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err,
    output imem_rvalid, imem_rdata, instr_ready, pc_src, pc_target, flush, flush_pc
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection.
//  clk, rst   : clock, asynchronous active-high reset (loads RESET_PC)
//  flush      : load flush_pc (highest priority)
//  advance    : instruction consumed; load pc_target if pc_src else pc+4
//  pc         : current word-aligned PC
// Both redirect sources have their two low bits forced to zero; pc+4 wraps.
module fetch_pc_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            advance,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = flush_pc & ALIGN_MASK;
    end else if (advance) begin
      pc_d = pc_src ? (pc_target & ALIGN_MASK) : (pc_q + XLEN'(4));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage. Owns the PC, issues one request at a
// time to instruction memory, and holds the returned word until the core
// consumes it. Handles branch redirects on consume, external flushes, and a
// memory timeout that parks the unit in ERR until flushed.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : instr_fetch_unit_if master (imem request/response, held
//             instruction + consume, branch redirect, flush, fetch_err)
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  import riscv_pkg::*;

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_t    state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fetch_err_q, fetch_err_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            consume;
  logic [XLEN-1:0] pc;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .flush_pc  (bus.flush_pc),
    .advance   (consume),
    .pc_src    (bus.pc_src),
    .pc_target (bus.pc_target),
    .pc        (pc)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    drop_d      = drop_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    fetch_err_d = fetch_err_q;
    consume     = 1'b0;

    if (bus.flush) begin
      fetch_err_d = 1'b0;
      timer_d     = '0;
      unique case (state_q)
        // A request is (or is about to be) in flight: keep waiting for it,
        // but mark its response for discard.
        FETCH: begin
          drop_d  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: begin
          drop_d  = 1'b0;
          state_d = FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          timer_d = '0;
          state_d = WAIT;
        end
        WAIT: begin
          timer_d = timer_q + 1'b1;
          if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH;
            end else begin
              instr_d    = bus.imem_rdata;
              instr_pc_d = pc;
              state_d    = HOLD;
            end
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            // A pending discard is meaningless once the request is abandoned.
            fetch_err_d = 1'b1;
            drop_d      = 1'b0;
            state_d     = ERR;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            consume = 1'b1;
            state_d = FETCH;
          end
        end
        ERR: state_d = ERR;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they are Moore-stable.
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      drop_q        <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= RESET_PC;
      fetch_err_q   <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_err_q   <= fetch_err_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus();

  instr_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // ---------------- memory responder ----------------
  int          mem_lat     = 1;   // 0 = never respond
  bit          rand_mode   = 1'b0;
  bit          force_stale = 1'b0;
  bit          pend        = 1'b0;
  int          cnt         = 0;
  logic [31:0] paddr       = '0;

  // ---------------- behavioural model ----------------
  // Tracks the fetch as request/response bookkeeping: a request being
  // issued, one in flight (possibly to be discarded), a held word, an error.
  bit          m_boot, m_issue, m_inflight, m_stale, m_held, m_err;
  int          m_waited;
  logic [31:0] m_pc, m_instr, m_ipc;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_boot = 1; m_issue = 0; m_inflight = 0; m_stale = 0; m_held = 0; m_err = 0;
        m_waited = 0; m_pc = RESET_PC; m_ipc = RESET_PC; m_instr = '0;
      end else begin
        if (bus.flush) begin
          m_boot = 0; m_pc = bus.flush_pc & ~32'h3; m_err = 0; m_held = 0;
          if (m_issue) begin
            m_issue = 0; m_inflight = 1; m_stale = 1; m_waited = 0;
          end else if (m_inflight && !bus.imem_rvalid) begin
            m_stale = 1; m_waited = 0;
          end else begin
            m_inflight = 0; m_stale = 0; m_issue = 1;
          end
        end else if (m_boot) begin
          m_boot = 0; m_issue = 1;
        end else if (m_issue) begin
          m_issue = 0; m_inflight = 1; m_waited = 0;
        end else if (m_inflight) begin
          if (bus.imem_rvalid) begin
            m_inflight = 0;
            if (m_stale) begin
              m_stale = 0; m_issue = 1;
            end else begin
              m_held = 1; m_instr = memword(m_pc); m_ipc = m_pc;
            end
          end else if (m_waited == TIMEOUT - 1) begin
            m_inflight = 0; m_stale = 0; m_err = 1;
          end else begin
            m_waited++;
          end
        end else if (m_held && bus.instr_ready) begin
          m_held = 0; m_issue = 1;
          m_pc = bus.pc_src ? (bus.pc_target & ~32'h3) : (m_pc + 32'd4);
        end
      end
    end
  end

  // Compare process plus memory responder, both on the falling edge.
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("imem_req", bus.imem_req, m_issue);
        if (m_issue) check("imem_addr", bus.imem_addr, m_pc);
        check("instr_valid", bus.instr_valid, m_held);
        if (m_held) begin
          check("instr", bus.instr, m_instr);
          check("instr_pc", bus.instr_pc, m_ipc);
        end
        check("fetch_err", bus.fetch_err, m_err);
      end
      if (rst) begin
        pend = 0;
        bus.imem_rvalid = 1'b0;
      end else begin
        bus.imem_rvalid = 1'b0;
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = force_stale ? 32'hDEADBEEF : memword(paddr);
          end
        end else if (rand_mode && $urandom_range(0, 7) == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = 32'hDEADBEEF;
        end
        if (bus.imem_req) begin
          int lat;
          if (rand_mode) lat = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 4));
          else           lat = mem_lat;
          pend  = 1;
          cnt   = (lat == 0) ? 1000000 : lat;
          paddr = bus.imem_addr;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: instr_valid never rose within 40 cycles", name);
    end
  endtask

  task automatic wait_req(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: imem_req never rose within 40 cycles", name);
    end
  endtask

  // Consume the held instruction; returns at the falling edge where the next
  // request must already be visible, and checks its address.
  task automatic consume(input string name, input bit src, input logic [31:0] tgt,
                         input logic [31:0] exp_addr);
    bus.instr_ready = 1'b1;
    bus.pc_src      = src;
    bus.pc_target   = tgt;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.pc_src      = 1'b0;
    check({name, "_req"}, bus.imem_req, 1'b1);
    check({name, "_addr"}, bus.imem_addr, exp_addr);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    bus.instr_ready = 1'b0;
    bus.pc_src      = 1'b0;
    bus.pc_target   = '0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    check("rst_instr_pc", bus.instr_pc, RESET_PC);
    check("rst_fetch_err", bus.fetch_err, 1'b0);
    rst = 1'b0;

    // 1: first fetch, latency 1
    @(negedge clk);
    check("t1_req", bus.imem_req, 1'b1);
    check("t1_addr", bus.imem_addr, 32'h0);
    repeat (2) @(negedge clk);
    check("t1_valid", bus.instr_valid, 1'b1);
    check("t1_instr", bus.instr, 32'h00500093);
    check("t1_pc", bus.instr_pc, 32'h0);
    consume("t1_next", 1'b0, 32'h0, 32'h4);

    // 2: branch and sequential from pc 0x8
    wait_valid("t2_v4");
    consume("t2_seq", 1'b0, 32'h0, 32'h8);
    wait_valid("t2_v8");
    check("t2_pc8", bus.instr_pc, 32'h8);
    consume("t2_br", 1'b1, 32'h22, 32'h20);
    wait_valid("t2_v20");
    consume("t2_back", 1'b1, 32'h8, 32'h8);
    wait_valid("t2_v8b");
    consume("t2_seq8", 1'b0, 32'h0, 32'hC);

    // 3: stall in HOLD with pc_src asserted but no consume
    wait_valid("t3_v");
    bus.pc_src    = 1'b1;
    bus.pc_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", bus.instr_valid, 1'b1);
      check("t3_hold_pc", bus.instr_pc, 32'hC);
      check("t3_hold_instr", bus.instr, memword(32'hC));
      check("t3_hold_noreq", bus.imem_req, 1'b0);
    end
    consume("t3_go", 1'b0, 32'h80, 32'h10);

    // 4: flush in WAIT, stale response arrives two cycles later
    wait_valid("t4_v");
    mem_lat     = 3;
    force_stale = 1'b1;
    consume("t4_req", 1'b0, 32'h0, 32'h14);
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h100;
    @(negedge clk);
    bus.flush = 1'b0;
    check("t4_flush_novalid", bus.instr_valid, 1'b0);
    wait_req("t4_refetch");
    check("t4_addr", bus.imem_addr, 32'h100);
    force_stale = 1'b0;
    wait_valid("t4_v100");
    check("t4_instr", bus.instr, memword(32'h100));
    mem_lat = 0;

    // 5: timeout, then recovery by flush
    consume("t5_req", 1'b0, 32'h0, 32'h104);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.fetch_err) begin
        n = i;
        break;
      end
    end
    check("t5_err_cycles", n, 17);
    mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_err_sticky", bus.fetch_err, 1'b1);
      check("t5_err_noreq", bus.imem_req, 1'b0);
    end
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h40;
    @(negedge clk);
    bus.flush = 1'b0;
    check("t5_err_clr", bus.fetch_err, 1'b0);
    check("t5_req", bus.imem_req, 1'b1);
    check("t5_addr", bus.imem_addr, 32'h40);
    wait_valid("t5_v40");
    check("t5_pc40", bus.instr_pc, 32'h40);

    // 6: misaligned flush target, wrap of pc+4, async reset mid-WAIT
    bus.flush    = 1'b1;
    bus.flush_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    bus.flush = 1'b0;
    check("t6_align_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_valid("t6_vtop");
    check("t6_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
    consume("t6_wrap", 1'b0, 32'h0, 32'h0);
    wait_valid("t6_v0");
    consume("t6_to4", 1'b0, 32'h0, 32'h4);
    wait_valid("t6_v4");
    mem_lat = 3;
    consume("t6_to8", 1'b0, 32'h0, 32'h8);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_req", bus.imem_req, 1'b0);
    check("t6_rst_valid", bus.instr_valid, 1'b0);
    check("t6_rst_pc", bus.instr_pc, RESET_PC);
    check("t6_rst_err", bus.fetch_err, 1'b0);
    mem_lat = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_req", bus.imem_req, 1'b1);
    check("t6_post_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.instr_ready = ($urandom_range(0, 2) != 0);
      bus.pc_src      = $urandom_range(0, 1) == 1;
      bus.pc_target   = $urandom;
      bus.flush       = ($urandom_range(0, 39) == 0);
      bus.flush_pc    = $urandom;
    end
    @(negedge clk);
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    rand_mode       = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
